// File: rtl/rf_pkg.sv
// rf_pkg: shared scheduler state encoding and timing constants.
package rf_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_AVAI, S_RUN, S_SETTLE, S_CLOSE
  } sched_state_t;
  localparam int SCHED_SETTLE_CYCLES = 2;
endpackage

// File: rtl/dtp_sample_scheduler_if.sv
// dtp_sample_scheduler_if: host, attribute RAM and DTP array signals of the sample scheduler.
interface dtp_sample_scheduler_if #(
  parameter int N_DTPS = 4,
  parameter int CNT_W  = 16
);
  logic              i_batch_start;
  logic [CNT_W-1:0]  i_batch_len;
  logic              i_abort;
  logic              o_att_ram_start;
  logic              o_att_ram_end;
  logic              i_is_att_ram_avai;
  logic              i_is_sample_done;
  logic [N_DTPS-1:0] o_dtp_start;
  logic [N_DTPS-1:0] i_dtp_done;
  logic [N_DTPS-1:0] o_att_ram_switch;
  logic [CNT_W-1:0]  o_sample_cnt;
  logic              o_busy;
  logic              o_batch_done;
  logic              o_err;
  modport master (
    input  i_batch_start, i_batch_len, i_abort, i_is_att_ram_avai, i_is_sample_done, i_dtp_done,
    output o_att_ram_start, o_att_ram_end, o_dtp_start, o_att_ram_switch, o_sample_cnt, o_busy,
           o_batch_done, o_err
  );
  modport slave (
    output i_batch_start, i_batch_len, i_abort, i_is_att_ram_avai, i_is_sample_done, i_dtp_done,
    input  o_att_ram_start, o_att_ram_end, o_dtp_start, o_att_ram_switch, o_sample_cnt, o_busy,
           o_batch_done, o_err
  );
endinterface

// File: rtl/dtp_sample_scheduler_done_tracker.sv
// dtp_done_tracker: per-sample DTP completion mask, duplicate filter and registered bank-switch pulses.
module dtp_done_tracker #(
  parameter int N_DTPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              flush_i,
  input  logic [N_DTPS-1:0] done_i,
  output logic [N_DTPS-1:0] switch_o,
  output logic              all_done_o
);
  logic [N_DTPS-1:0] mask_q, mask_d, switch_q, switch_d, new_done;
  always_comb begin
    new_done   = run_i ? done_i & ~mask_q : '0;
    all_done_o = run_i && &(mask_q | new_done);
    mask_d     = (run_i && !all_done_o && !flush_i) ? mask_q | new_done : '0;
    switch_d   = flush_i ? '0 : new_done;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q   <= '0;
      switch_q <= '0;
    end else begin
      mask_q   <= mask_d;
      switch_q <= switch_d;
    end
  end
  assign switch_o = switch_q;
endmodule

// File: rtl/dtp_sample_scheduler.sv
// dtp_sample_scheduler: sequences the DTP array over a batch of samples in the attribute RAM.
// Optional run watchdog enabled by SCHED_WATCHDOG_EN.
module dtp_sample_scheduler
  import rf_pkg::*;
#(
  parameter int N_DTPS     = 4,
  parameter int CNT_W      = 16,
  parameter int WDT_CYCLES = 4096
) (
  input logic clk,
  input logic rst_n,
  dtp_sample_scheduler_if.master bus
);
  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, len_q;
  logic [N_DTPS-1:0] dtp_start_q;
  logic [1:0]        settle_q;
  logic              wait_q, all_done, wdt_close, start, len_hit, run;
  assign start   = state_q == S_IDLE && bus.i_batch_start;
  assign len_hit = len_q != '0 && cnt_q == len_q;
  assign run     = state_q == S_RUN;
  dtp_done_tracker #(.N_DTPS(N_DTPS)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (run),
    .flush_i   (bus.i_abort),
    .done_i    (bus.i_dtp_done),
    .switch_o  (bus.o_att_ram_switch),
    .all_done_o(all_done)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      state_d = bus.i_batch_start ? S_ARM : S_IDLE;
      S_ARM:       state_d = S_WAIT_AVAI;
      S_WAIT_AVAI: state_d = (bus.i_abort || len_hit) ? S_CLOSE :
                             bus.i_is_att_ram_avai ? S_RUN :
                             (wait_q && bus.i_is_sample_done) ? S_CLOSE : S_WAIT_AVAI;
      S_RUN:       state_d = bus.i_abort ? S_CLOSE : all_done ? S_SETTLE :
                             wdt_close ? S_CLOSE : S_RUN;
      S_SETTLE:    state_d = bus.i_abort ? S_CLOSE :
                             settle_q == 2'(SCHED_SETTLE_CYCLES - 1) ? S_WAIT_AVAI : S_SETTLE;
      S_CLOSE:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end
  // wait_q is low on the first WAIT_AVAI cycle, masking a stale sample-done from the RAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      dtp_start_q <= '0;
      settle_q    <= '0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= start ? '0 : (run && all_done && !bus.i_abort) ? cnt_q + 1'b1 : cnt_q;
      len_q       <= start ? bus.i_batch_len : len_q;
      dtp_start_q <= (state_q == S_WAIT_AVAI && state_d == S_RUN) ? '1 : '0;
      settle_q    <= state_q == S_SETTLE ? settle_q + 2'd1 : 2'd0;
      wait_q      <= state_q == S_WAIT_AVAI;
    end
  end
`ifdef SCHED_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q;
  logic             err_q;
  assign wdt_close = run && wdt_q == WDT_W'(WDT_CYCLES - 1) && !bus.i_abort && !all_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdt_q <= run ? wdt_q + 1'b1 : '0;
      err_q <= start ? 1'b0 : err_q | wdt_close;
    end
  end
  assign bus.o_err = err_q;
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
  assign wdt_close  = 1'b0;
  assign bus.o_err  = 1'b0;
`endif
  assign bus.o_att_ram_start = state_q == S_ARM;
  assign bus.o_att_ram_end   = state_q == S_CLOSE;
  assign bus.o_batch_done    = state_q == S_CLOSE;
  assign bus.o_busy          = state_q != S_IDLE;
  assign bus.o_dtp_start     = dtp_start_q;
  assign bus.o_sample_cnt    = cnt_q;
endmodule
